micro_nonce_ctrl: RTL
=====================

# micro_nonce_ctrl

Upstream controller for the mining datapath's `micro_hash` core. It takes a 96-bit block header, appends a 32-bit nonce to form the 16-byte message block, and hands that block to the hash stage. It then waits for the hash result and checks it against the target. On a miss it increments the nonce and retries; on a hit, or once the nonce range is spent, it stops and reports.

## Interface
Parameters:
- `NONCE_START`, 32'h0000_0000: first nonce tried after `start`.
- `NONCE_LAST`, 32'hFFFF_FFFF: final nonce tried before the search is declared exhausted.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low; 0 clears all state.
- `start`  in  1  one-cycle pulse; begins a search; honoured only in IDLE, FOUND or EXHAUSTED.
- `header`  in  96  block header; byte0 = [95:88] … byte11 = [7:0]; captured on accepted `start`.
- `target`  in  8  difficulty byte; captured on accepted `start`.
- `blk_valid`  out  1  block offered to hash stage.
- `blk_ready`  in  1  hash stage accepts block.
- `blk_data`  out  128  byte i = [127-8i -: 8]; bytes 0–11 = header, bytes 12–15 = nonce, MSB first.
- `hash_valid`  in  1  one-cycle strobe from hash stage.
- `hash_in`  in  24  {H0, H1, H2}; H0 = [23:16].
- `busy`  out  1  search in progress.
- `found`  out  1  hit; held until next accepted `start`.
- `exhausted`  out  1  range spent with no hit; held until next accepted `start`.
- `nonce_out`  out  32  winning nonce; valid while `found`.
- `hash_out`  out  24  winning hash; valid while `found`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUSTED.
- IDLE/FOUND/EXHAUSTED, `start`=1:
  - capture `header` and `target`;
  - nonce ← `NONCE_START`;
  - clear `found`, `exhausted`, `nonce_out`, `hash_out`;
  - go to ISSUE.
- Other inputs in these three states: ignored.
- ISSUE:
  - `blk_valid`=1; `blk_data` stable.
  - `blk_valid`&`blk_ready` → WAIT; `blk_valid` deasserts the following cycle.
  - Without ready, hold valid and data indefinitely.
- WAIT: `hash_valid`=1 → register `hash_in` → CHECK.
- CHECK, hit = (H0 < target) && (H1 < target), unsigned 8-bit compare:
  - hit → FOUND; `nonce_out` ← nonce, `hash_out` ← registered hash.
  - miss and nonce == `NONCE_LAST` → EXHAUSTED.
  - miss otherwise → nonce ← nonce + 1 (32-bit wrap) → ISSUE.
- `busy`=1 in ISSUE, WAIT and CHECK.
- `start` while busy: ignored.
- `hash_valid` outside WAIT: ignored.
- `target` = 0: a hit is impossible, so the search always ends in EXHAUSTED.
- `NONCE_START` == `NONCE_LAST`: exactly one attempt.
- `NONCE_START` > `NONCE_LAST`: the nonce wraps through 0 up to `NONCE_LAST`.

## Timing
- Reset (`reset`=0 at a rising edge):
  - next cycle: state IDLE;
  - `blk_valid`, `busy`, `found`, `exhausted` = 0;
  - `blk_data`, `nonce_out`, `hash_out` = 0.
- Reset mid-search abandons the search; no partial result is reported.
- `start` sampled at edge 0 → `blk_valid`=1 and `busy`=1 from cycle 1.
- Handshake completes at edge n (valid&ready) → `blk_valid`=0 from cycle n+1.
- `hash_valid` sampled at edge m → state CHECK in cycle m+1. Cycle m+2 shows one of:
  - `found`=1 with `nonce_out` and `hash_out`;
  - `exhausted`=1;
  - `blk_valid`=1 carrying nonce+1.
- Miss turnaround (hash strobe to next block offered): 2 cycles.
- Every output is driven from a register; there are no combinational input-to-output paths.

## Structure
- Shared package `micro_pkg` holds:
  - state enum `nonce_state_t`;
  - constants `HDR_BYTES`=12, `NONCE_BYTES`=4, `BLK_BYTES`=16, `HASH_BYTES`=3.
- Sub-module `micro_target_cmp`:
  - combinational;
  - inputs `hash[23:0]`, `target[7:0]`; output `hit`;
  - reused by the downstream result checker.

## Test plan
- Reset then idle: `reset`=0 for 2 cycles, then 1, no `start` → all outputs 0; `blk_valid` never rises.
- First-try hit:
  - stimulus: `header`=96'h0123…AB, `target`=8'h80; mock hash returns 24'h10_20_FF for the block accepted 3 cycles earlier;
  - response: `found`=1 at hash strobe + 2; `nonce_out`=0; `hash_out`=24'h10_20_FF; `blk_data[31:0]`=0.
- Hit on nonce 5:
  - stimulus: mock returns 24'hFF_00_00 for nonces 0–4, then 24'h01_02_03;
  - response: six handshakes, nonce bytes 0…5 in order; `nonce_out`=5.
- Exhaustion: `NONCE_START`=32'hFFFF_FFFE, `NONCE_LAST`=32'h0000_0001, `target`=0 → four attempts (FFFF_FFFE, FFFF_FFFF, 0, 1), then `exhausted`=1, `found`=0.
- Backpressure and stray strobes:
  - stimulus: hold `blk_ready`=0 for 7 cycles; pulse `hash_valid` during ISSUE;
  - response: `blk_valid` and `blk_data` stable throughout; stray strobe ignored; search result unaffected.
- Restart and reset mid-search:
  - `start` in WAIT → ignored.
  - `start` in FOUND → `found` cleared and search restarted at `NONCE_START`.
  - `reset`=0 during WAIT → IDLE with all outputs 0 the next cycle.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared types and sizes for the micro_hash mining datapath.
package micro_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        FOUND,
        EXHAUSTED
    } nonce_state_t;

    localparam int HDR_BYTES   = 12;
    localparam int NONCE_BYTES = 4;
    localparam int BLK_BYTES   = 16;
    localparam int HASH_BYTES  = 3;

    localparam int HDR_W   = HDR_BYTES * 8;
    localparam int NONCE_W = NONCE_BYTES * 8;
    localparam int BLK_W   = BLK_BYTES * 8;
    localparam int HASH_W  = HASH_BYTES * 8;

endpackage

// File: rtl/micro_target_cmp.sv
// Difficulty compare: a hash hits when both H0 and H1 are strictly below
// the target byte (unsigned). H2 does not take part in the decision.
module micro_target_cmp
    import micro_pkg::*;
(
    input  logic [HASH_W-1:0] hash,
    input  logic [7:0]        target,
    output logic              hit
);

    logic [7:0] h0;
    logic [7:0] h1;
    logic       unused_h2;

    assign h0        = hash[23:16];
    assign h1        = hash[15:8];
    assign unused_h2 = ^hash[7:0];
    assign hit       = (h0 < target) && (h1 < target);

endmodule

// File: rtl/micro_nonce_ctrl.sv
// Nonce search controller: builds header+nonce blocks for micro_hash,
// checks each returned hash against the target and stops on a hit or
// when the nonce range is spent. All outputs come straight from flops.
module micro_nonce_ctrl
    import micro_pkg::*;
#(
    parameter logic [NONCE_W-1:0] NONCE_START = 32'h0000_0000,
    parameter logic [NONCE_W-1:0] NONCE_LAST  = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [HDR_W-1:0]   header,
    input  logic [7:0]         target,
    output logic               blk_valid,
    input  logic               blk_ready,
    output logic [BLK_W-1:0]   blk_data,
    input  logic               hash_valid,
    input  logic [HASH_W-1:0]  hash_in,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] nonce_out,
    output logic [HASH_W-1:0]  hash_out
);

    nonce_state_t        state_q;
    nonce_state_t        state_d;
    logic [HDR_W-1:0]    hdr_q;
    logic [7:0]          tgt_q;
    logic [NONCE_W-1:0]  nonce_q;
    logic [HASH_W-1:0]   hash_q;
    logic                hit;
    logic                last_nonce;

    micro_target_cmp u_cmp (
        .hash   (hash_q),
        .target (tgt_q),
        .hit    (hit)
    );

    assign last_nonce = (nonce_q == NONCE_LAST);
    assign blk_data   = {hdr_q, nonce_q};

    // State register; reset abandons any search in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode. blk_valid is high for the whole of ISSUE, so
    // blk_ready alone completes the handshake there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FOUND, EXHAUSTED: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                if (blk_ready) state_d = WAIT;
            end
            WAIT: begin
                if (hash_valid) state_d = CHECK;
            end
            CHECK: begin
                if (hit)             state_d = FOUND;
                else if (last_nonce) state_d = EXHAUSTED;
                else                 state_d = ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Search context, registered handshake/status flags and the result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hdr_q     <= '0;
            tgt_q     <= '0;
            nonce_q   <= '0;
            hash_q    <= '0;
            blk_valid <= 1'b0;
            busy      <= 1'b0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            nonce_out <= '0;
            hash_out  <= '0;
        end else begin
            blk_valid <= (state_d == ISSUE);
            busy      <= (state_d inside {ISSUE, WAIT, CHECK});
            case (state_q)
                IDLE, FOUND, EXHAUSTED: begin
                    if (start) begin
                        hdr_q     <= header;
                        tgt_q     <= target;
                        nonce_q   <= NONCE_START;
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        nonce_out <= '0;
                        hash_out  <= '0;
                    end
                end
                WAIT: begin
                    if (hash_valid) hash_q <= hash_in;
                end
                CHECK: begin
                    if (hit) begin
                        found     <= 1'b1;
                        nonce_out <= nonce_q;
                        hash_out  <= hash_q;
                    end else if (last_nonce) begin
                        exhausted <= 1'b1;
                    end else begin
                        nonce_q   <= nonce_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
